rc4_seq_ctrl: RTL
=================

RC4_SEQ_CTRL -- requirements
Module: rc4_seq_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: en in 1 (start request), rdy out 1 (ready for en), done out 1 (run complete), key in 24 (RC4 key).
REQ-004 SHALL have ports: init_en out 1, init_rdy in 1, init_addr in 8, init_wrdata in 8, init_wren in 1.
REQ-005 SHALL have ports: ksa_en out 1, ksa_rdy in 1, ksa_key out 24, ksa_addr in 8, ksa_wrdata in 8, ksa_wren in 1.
REQ-006 SHALL have ports: prga_en out 1, prga_rdy in 1, prga_addr in 8, prga_wrdata in 8, prga_wren in 1.
REQ-007 SHALL have ports: host_addr in 8 (S readback address); s_addr out 8, s_wrdata out 8, s_wren out 1 (single S-memory port).
REQ-008 SHALL have ports: phase out 3 (current state code), cycle_count out 16 (run length).

Function
REQ-009 SHALL implement states IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA, DONE.
REQ-010 SHALL assert rdy only in IDLE and DONE; en sampled high there latches key into a 24-bit register and moves to START_INIT next edge.
REQ-011 SHALL ignore en in every other state; key register unchanged while busy.
REQ-012 SHALL drive X_en=1 for exactly one cycle in START_X, only when X_rdy=1; if X_rdy=0, hold in START_X with X_en=0.
REQ-013 SHALL move START_X -> WAIT_X on the edge where X_en=1 is sampled; sub-blocks drop X_rdy on that same edge.
REQ-014 SHALL leave WAIT_X on the first cycle X_rdy=1: WAIT_INIT->START_KSA, WAIT_KSA->START_PRGA, WAIT_PRGA->DONE.
REQ-015 SHALL hold ksa_key equal to the latched key at all times.
REQ-016 SHALL set S-port owner combinationally from state: INIT in START_INIT/WAIT_INIT, KSA in START_KSA/WAIT_KSA, PRGA in START_PRGA/WAIT_PRGA, HOST in IDLE/DONE.
REQ-017 SHALL pass owner addr/wrdata/wren to s_addr/s_wrdata/s_wren; non-owner wren has no effect.
REQ-018 SHALL, for owner HOST, drive s_addr=host_addr, s_wrdata=0, s_wren=0.
REQ-019 SHALL assert done only in DONE; DONE holds until a new en, which restarts from START_INIT.
REQ-020 SHALL keep at most one X_en high in any cycle.

Reset
REQ-021 SHALL on rst_n=0 immediately enter IDLE: rdy=1, done=0, all X_en=0, key register=0, phase=IDLE, cycle_count=0.
REQ-022 SHALL abort any run on mid-operation reset; S contents are then undefined and no sub-block en fires until a new en.

Configuration
REQ-023 SHALL compile a run-cycle counter when RC4_CYCLE_CNT_EN is defined: cleared on accepted en, +1 per cycle outside IDLE/DONE, saturates at 16'hFFFF, held in DONE.
REQ-024 SHALL, without RC4_CYCLE_CNT_EN, tie cycle_count to 16'h0000 and omit the counter register.

Structure
REQ-025 SHALL place state enum, owner enum, KEY_W=24, ADDR_W=8, DATA_W=8 in shared package rc4_pkg.
REQ-026 SHALL implement the S-port selection as one combinational sub-module rc4_s_mux (owner, four source buses -> s_addr/s_wrdata/s_wren).

Verification
REQ-027 SHALL cover reset: rst_n=0 at any state -> rdy=1, done=0, init_en=ksa_en=prga_en=0, s_wren=0, phase=IDLE within the same cycle.
REQ-028 SHALL cover sequencing with stubs (init 257, ksa 2562, prga 100 cycles): key=24'h00033C, en 1 cycle -> one init_en pulse next cycle, one ksa_en pulse 1 cycle after init_rdy rises, one prga_en after ksa, done after prga_rdy.
REQ-029 SHALL cover end-to-end with real init/ksa and key=24'h00033C: after WAIT_KSA, S[0]=8'hB4, S[1]=8'h04, S[255]=8'h1B read via host_addr in DONE.
REQ-030 SHALL cover ownership: stub init_wren=1 forced during WAIT_KSA with ksa_wren=0 -> s_wren=0; host_addr=8'h10 during WAIT_INIT -> s_addr=init_addr.
REQ-031 SHALL cover busy/abort: en pulses during WAIT_KSA ignored (key unchanged, no extra init_en); rst_n pulse mid-KSA -> IDLE, new en restarts at START_INIT.
REQ-032 SHALL cover RC4_CYCLE_CNT_EN: defined -> cycle_count equals run cycles (stub run: 2925±3) in DONE; undefined -> cycle_count=0 throughout.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 sequencing controller and its S-memory port mux.
package rc4_pkg;

  localparam int KEY_W  = 24;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Encodings are visible on the phase output, so keep them stable.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_INIT = 3'd1,
    ST_WAIT_INIT  = 3'd2,
    ST_START_KSA  = 3'd3,
    ST_WAIT_KSA   = 3'd4,
    ST_START_PRGA = 3'd5,
    ST_WAIT_PRGA  = 3'd6,
    ST_DONE       = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    OWN_HOST = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
  } s_bus_t;

  function automatic owner_e owner_of(input state_e st);
    case (st)
      ST_START_INIT, ST_WAIT_INIT: return OWN_INIT;
      ST_START_KSA,  ST_WAIT_KSA:  return OWN_KSA;
      ST_START_PRGA, ST_WAIT_PRGA: return OWN_PRGA;
      default:                     return OWN_HOST;
    endcase
  endfunction

endpackage

// File: rtl/rc4_seq_ctrl_if.sv
// Handshake and S-memory bus bundle between the RC4 controller (slave) and its environment (master).
interface rc4_seq_ctrl_if;

  logic                      en;
  logic                      rdy;
  logic                      done;
  logic [rc4_pkg::KEY_W-1:0] key;

  logic                       init_en;
  logic                       init_rdy;
  logic [rc4_pkg::ADDR_W-1:0] init_addr;
  logic [rc4_pkg::DATA_W-1:0] init_wrdata;
  logic                       init_wren;

  logic                       ksa_en;
  logic                       ksa_rdy;
  logic [rc4_pkg::KEY_W-1:0]  ksa_key;
  logic [rc4_pkg::ADDR_W-1:0] ksa_addr;
  logic [rc4_pkg::DATA_W-1:0] ksa_wrdata;
  logic                       ksa_wren;

  logic                       prga_en;
  logic                       prga_rdy;
  logic [rc4_pkg::ADDR_W-1:0] prga_addr;
  logic [rc4_pkg::DATA_W-1:0] prga_wrdata;
  logic                       prga_wren;

  logic [rc4_pkg::ADDR_W-1:0] host_addr;
  logic [rc4_pkg::ADDR_W-1:0] s_addr;
  logic [rc4_pkg::DATA_W-1:0] s_wrdata;
  logic                       s_wren;

  logic [2:0]  phase;
  logic [15:0] cycle_count;

  modport slave (
    input  en, key, host_addr,
    input  init_rdy, init_addr, init_wrdata, init_wren,
    input  ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    input  prga_rdy, prga_addr, prga_wrdata, prga_wren,
    output rdy, done, init_en, ksa_en, ksa_key, prga_en,
    output s_addr, s_wrdata, s_wren, phase, cycle_count
  );

  modport master (
    output en, key, host_addr,
    output init_rdy, init_addr, init_wrdata, init_wren,
    output ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    output prga_rdy, prga_addr, prga_wrdata, prga_wren,
    input  rdy, done, init_en, ksa_en, ksa_key, prga_en,
    input  s_addr, s_wrdata, s_wren, phase, cycle_count
  );

endinterface

// File: rtl/rc4_seq_ctrl_s_mux.sv
// Purely combinational S-memory port selector: the current owner's bus goes straight to the memory.
module rc4_s_mux
  import rc4_pkg::*;
(
  input  owner_e            owner,
  input  s_bus_t            host_bus,
  input  s_bus_t            init_bus,
  input  s_bus_t            ksa_bus,
  input  s_bus_t            prga_bus,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  s_bus_t sel;

  always_comb begin
    // NOTE: assign a default before the case so every path drives sel and no latch is inferred.
    sel = host_bus;
    case (owner)
      OWN_INIT: sel = init_bus;
      OWN_KSA:  sel = ksa_bus;
      OWN_PRGA: sel = prga_bus;
      default:  sel = host_bus;
    endcase
  end

  assign s_addr   = sel.addr;
  assign s_wrdata = sel.wrdata;
  assign s_wren   = sel.wren;

endmodule

// File: rtl/rc4_seq_ctrl.sv
// RC4 run sequencer: starts init, KSA and PRGA in turn and hands the S port to whichever is active.
// Optional run-cycle counter compiled in with `define RC4_CYCLE_CNT_EN.
module rc4_seq_ctrl
  import rc4_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  rc4_seq_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q;
  logic              rdy, done, init_en, ksa_en, prga_en;
  logic              accept;

  assign accept = rdy & bus.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (accept) key_q <= bus.key;
    end
  end

  // Each START state fires its enable only while the sub-block is ready, and
  // leaves on the edge that samples the enable.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    done    = 1'b0;
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (bus.en) state_d = ST_START_INIT;
      end
      ST_START_INIT: if (bus.init_rdy) begin
        init_en = 1'b1;
        state_d = ST_WAIT_INIT;
      end
      ST_WAIT_INIT:  if (bus.init_rdy) state_d = ST_START_KSA;
      ST_START_KSA:  if (bus.ksa_rdy) begin
        ksa_en  = 1'b1;
        state_d = ST_WAIT_KSA;
      end
      ST_WAIT_KSA:   if (bus.ksa_rdy) state_d = ST_START_PRGA;
      ST_START_PRGA: if (bus.prga_rdy) begin
        prga_en = 1'b1;
        state_d = ST_WAIT_PRGA;
      end
      ST_WAIT_PRGA:  if (bus.prga_rdy) state_d = ST_DONE;
      ST_DONE: begin
        rdy  = 1'b1;
        done = 1'b1;
        if (bus.en) state_d = ST_START_INIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rdy     = rdy;
  assign bus.done    = done;
  assign bus.init_en = init_en;
  assign bus.ksa_en  = ksa_en;
  assign bus.prga_en = prga_en;
  assign bus.ksa_key = key_q;
  assign bus.phase   = state_q;

  s_bus_t host_bus, init_bus, ksa_bus, prga_bus;

  assign host_bus = '{addr: bus.host_addr, wrdata: '0, wren: 1'b0};
  assign init_bus = '{addr: bus.init_addr, wrdata: bus.init_wrdata, wren: bus.init_wren};
  assign ksa_bus  = '{addr: bus.ksa_addr,  wrdata: bus.ksa_wrdata,  wren: bus.ksa_wren};
  assign prga_bus = '{addr: bus.prga_addr, wrdata: bus.prga_wrdata, wren: bus.prga_wren};

  rc4_s_mux u_s_mux (
    .owner    (owner_of(state_q)),
    .host_bus (host_bus),
    .init_bus (init_bus),
    .ksa_bus  (ksa_bus),
    .prga_bus (prga_bus),
    .s_addr   (bus.s_addr),
    .s_wrdata (bus.s_wrdata),
    .s_wren   (bus.s_wren)
  );

`ifdef RC4_CYCLE_CNT_EN
  logic [15:0] cnt_q;
  logic        busy;

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Cleared on the accepting edge, then counts every busy cycle; saturates, holds in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt_q <= '0;
    else if (accept)                      cnt_q <= '0;
    else if (busy && cnt_q != 16'hFFFF)   cnt_q <= cnt_q + 16'd1;
  end

  assign bus.cycle_count = cnt_q;
`else
  assign bus.cycle_count = 16'h0000;
`endif

endmodule
